// File: rtl/alu_pkg.sv
// Shared ALU definitions: comparator opcodes, flag bit positions, and the
// state encoding of the compare-sweep controller.
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_EQ  = 4'b0111;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_GT  = 4'b1010;
  localparam logic [3:0] OP_LT  = 4'b1011;
  localparam logic [3:0] OP_GE  = 4'b1110;
  localparam logic [3:0] OP_LE  = 4'b1111;

  localparam int unsigned FLG_EQ    = 0;
  localparam int unsigned FLG_NE    = 1;
  localparam int unsigned FLG_GT    = 2;
  localparam int unsigned FLG_LT    = 3;
  localparam int unsigned FLG_GE    = 4;
  localparam int unsigned FLG_LE    = 5;
  localparam int unsigned NUM_FLAGS = 6;

  localparam logic [2:0] SWEEP_LAST_IDX = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } sweep_state_t;

  // Sweep order matches the flag bit order, so flag[idx] pairs with opcode[idx].
  function automatic logic [3:0] sweep_opcode(input logic [2:0] idx);
    logic [3:0] op;
    case (idx)
      3'd0:    op = OP_EQ;
      3'd1:    op = OP_NE;
      3'd2:    op = OP_GT;
      3'd3:    op = OP_LT;
      3'd4:    op = OP_GE;
      3'd5:    op = OP_LE;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cmp_flag_check.sv
// Combinational consistency check of a six-relation flag vector; flags err
// when the relations cannot all hold for one operand pair.
module cmp_flag_check
  import alu_pkg::*;
(
  input  logic [5:0] flags,
  output logic       err
);

  logic eq, ne, gt, lt, ge, le;

  always_comb begin
    eq  = flags[FLG_EQ];
    ne  = flags[FLG_NE];
    gt  = flags[FLG_GT];
    lt  = flags[FLG_LT];
    ge  = flags[FLG_GE];
    le  = flags[FLG_LE];
    err = ~(eq ^ ne)
        | (gt & lt)
        | (ge != (gt | eq))
        | (le != (lt | eq));
  end

endmodule

// File: rtl/cmp_sweep_ctrl.sv
// Drives an external combinational comparator through all six relations for
// one operand pair and returns the collected flag vector with an error bit.
module cmp_sweep_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic [SEL_W-1:0] cmp_op_sel,
  input  logic [WIDTH-1:0] cmp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_flags,
  output logic             out_err
);

  sweep_state_t     state_q, state_d;
  logic [2:0]       idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [5:0]       flags_q, flags_next;
  logic             err_q;
  logic             range_err;
  logic             chk_err;
  logic             last_issue;

  // Vector as it will look after this cycle's result is written, so the
  // consistency error can be latched on the same edge as the final flag.
  always_comb begin
    flags_next        = flags_q;
    flags_next[idx_q] = cmp_result[0];
  end

  cmp_flag_check u_check (
    .flags (flags_next),
    .err   (chk_err)
  );

  always_comb begin
    range_err  = |cmp_result[WIDTH-1:1];
    last_issue = (idx_q == SWEEP_LAST_IDX);
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cmp_op_sel = SEL_W'(OP_NOP);
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ISSUE;
      end
      ISSUE: begin
        cmp_op_sel = SEL_W'(sweep_opcode(idx_q));
        if (last_issue) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            flags_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        ISSUE: begin
          flags_q <= flags_next;
          idx_q   <= idx_q + 3'd1;
          err_q   <= err_q | range_err | (last_issue & chk_err);
        end
        default: ;
      endcase
    end
  end

  assign cmp_a     = a_q;
  assign cmp_b     = b_q;
  assign out_flags = flags_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Scoreboard bench for cmp_sweep_ctrl with a behavioural comparator that can
// be switched into two faulty modes.
module tb_cmp_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b;
  logic [7:0] cmp_a, cmp_b;
  logic [3:0] cmp_op_sel;
  logic [7:0] cmp_result;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_flags;
  logic       out_err;

  int fault = 0;
  int applied = 0;
  int miscompares = 0;
  logic [6:0] sb[$];
  logic [3:0] opc_seq [6] = '{4'h7, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};

  cmp_sweep_ctrl #(.WIDTH(8), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .cmp_a      (cmp_a),
    .cmp_b      (cmp_b),
    .cmp_op_sel (cmp_op_sel),
    .cmp_result (cmp_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_flags  (out_flags),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  // fault 1: GT answers 8'h02; fault 2: EQ and NE both answer 1.
  always_comb begin
    cmp_result = 8'h00;
    case (cmp_op_sel)
      4'h7: cmp_result = {7'b0, cmp_a == cmp_b};
      4'h9: cmp_result = {7'b0, cmp_a != cmp_b};
      4'hA: cmp_result = {7'b0, cmp_a >  cmp_b};
      4'hB: cmp_result = {7'b0, cmp_a <  cmp_b};
      4'hE: cmp_result = {7'b0, cmp_a >= cmp_b};
      4'hF: cmp_result = {7'b0, cmp_a <= cmp_b};
      default: cmp_result = 8'h00;
    endcase
    if (fault == 1 && cmp_op_sel == 4'hA) cmp_result = 8'h02;
    if (fault == 2 && (cmp_op_sel == 4'h7 || cmp_op_sel == 4'h9)) cmp_result = 8'h01;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [7:0] a, input logic [7:0] b);
    logic eq, ne, gt, lt, ge, le, bad, err;
    logic [5:0] f;
    eq = (a == b); ne = (a != b); gt = (a > b);
    lt = (a < b);  ge = (a >= b); le = (a <= b);
    bad = 1'b0;
    if (fault == 1) begin gt = 1'b0; bad = 1'b1; end
    if (fault == 2) begin eq = 1'b1; ne = 1'b1; end
    f = {le, ge, lt, gt, ne, eq};
    err = bad | ~(eq ^ ne) | (gt & lt) | (ge != (gt | eq)) | (le != (lt | eq));
    sb.push_back({err, f});
  endtask

  // Entered #1 after an edge with the DUT idle; leaves it idle the same way.
  task automatic run_sweep(input logic [7:0] a, input logic [7:0] b, input int stall);
    logic [6:0] exp;
    int waited;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    applied++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    push_expected(a, b);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applied++;
      if (cmp_op_sel !== opc_seq[k] || cmp_a !== a || cmp_b !== b ||
          in_ready !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL issue_cycle%0d: op=%h a=%h b=%h rdy=%b vld=%b required op=%h a=%h b=%h rdy=0 vld=0",
                 k + 1, cmp_op_sel, cmp_a, cmp_b, in_ready, out_valid, opc_seq[k], a, b);
      end
      step();
    end
    applied++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: out_valid=%b in cycle 7 required 1", out_valid);
    end
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: no expected entry");
      exp = 7'h0;
    end else begin
      exp = sb.pop_front();
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_a = ~a; in_b = ~b;
      applied++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_flags !== exp[5:0] ||
          out_err !== exp[6] || cmp_a !== a || cmp_op_sel !== 4'h0) begin
        miscompares++;
        $display("FAIL stall%0d: vld=%b rdy=%b flags=%h err=%b a=%h op=%h required 1 0 %h %b %h 0",
                 s, out_valid, in_ready, out_flags, out_err, cmp_a, cmp_op_sel, exp[5:0], exp[6], a);
      end
      step();
    end
    in_valid = 1'b0;
    applied++;
    if (out_flags !== exp[5:0] || out_err !== exp[6]) begin
      miscompares++;
      $display("FAIL result a=%0d b=%0d: flags=%h err=%b required flags=%h err=%b",
               a, b, out_flags, out_err, exp[5:0], exp[6]);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    applied++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cmp_op_sel !== 4'h0 || cmp_a !== a) begin
      miscompares++;
      $display("FAIL release: vld=%b rdy=%b op=%h a=%h required 0 1 0 %h",
               out_valid, in_ready, cmp_op_sel, cmp_a, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;
    step(); step();
    applied++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_flags !== 6'h00 || out_err !== 1'b0 ||
        cmp_a !== 8'h00 || cmp_b !== 8'h00 || cmp_op_sel !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b vld=%b flags=%h err=%b a=%h b=%h op=%h required 1 0 00 0 00 00 0",
               in_ready, out_valid, out_flags, out_err, cmp_a, cmp_b, cmp_op_sel);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_equal();
    run_sweep(8'd5, 8'd5, 0);
  endtask

  task automatic test_unsigned();
    run_sweep(8'd200, 8'd3, 0);
    run_sweep(8'd3, 8'd200, 0);
  endtask

  task automatic test_boundaries();
    run_sweep(8'h00, 8'h00, 0);
    run_sweep(8'hFF, 8'h00, 0);
    run_sweep(8'h00, 8'hFF, 0);
    run_sweep(8'hFF, 8'hFF, 0);
    for (int i = 0; i < 4; i++)
      run_sweep(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
  endtask

  task automatic test_back_pressure();
    run_sweep(8'h40, 8'h41, 20);
  endtask

  task automatic test_reset_mid_issue();
    in_a = 8'd7; in_b = 8'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    applied++;
    if (cmp_op_sel !== 4'hB) begin
      miscompares++;
      $display("FAIL mid_issue_op: op=%h required b", cmp_op_sel);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    applied++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cmp_op_sel !== 4'h0 || out_flags !== 6'h00) begin
      miscompares++;
      $display("FAIL mid_issue_reset: rdy=%b vld=%b op=%h flags=%h required 1 0 0 00",
               in_ready, out_valid, cmp_op_sel, out_flags);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid !== 1'b0) seen++;
        step();
      end
      applied++;
      if (seen != 0) begin
        miscompares++;
        $display("FAIL aborted_sweep_valid: out_valid high %0d cycles required 0", seen);
      end
    end
    run_sweep(8'd1, 8'd2, 0);
  endtask

  task automatic test_faulty_gt();
    fault = 1;
    run_sweep(8'd200, 8'd3, 0);
    fault = 0;
  endtask

  task automatic test_faulty_eq_ne();
    fault = 2;
    run_sweep(8'd9, 8'd9, 0);
    fault = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_equal();
    test_unsigned();
    test_boundaries();
    test_back_pressure();
    test_reset_mid_issue();
    test_faulty_gt();
    test_faulty_eq_ne();
    test_equal();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
